// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: default widths and FSM encoding.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package sdram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    XFER = ST_XFER,
    DONE = ST_DONE
  } state_t;

  // One-hot per-client strobe for a selected client index.
  function automatic logic [1:0] onehot(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_port_arb_if.sv
// Client and controller signal bundle of the SDRAM port arbiter.
// Latency: none (wiring only).
// Backpressure: per-beat acks from the controller pace both clients.
interface sdram_port_arb_if;
  import sdram_pkg::*;

  logic [1:0]          cli_req;
  logic [1:0]          cli_we;
  logic [2*ADDR_W-1:0] cli_addr;
  logic [2*LEN_W-1:0]  cli_len;
  logic [2*DATA_W-1:0] cli_wdata;
  logic [1:0]          cli_grant;
  logic [1:0]          cli_wr_ack;
  logic [1:0]          cli_rd_valid;
  logic [DATA_W-1:0]   cli_rd_data;
  logic [1:0]          cli_done;
  logic [1:0]          cli_err;
  logic                mem_wr_req;
  logic                mem_rd_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LEN_W-1:0]    mem_len;
  logic [DATA_W-1:0]   mem_wr_data;
  logic                mem_wr_ack;
  logic                mem_rd_ack;
  logic [DATA_W-1:0]   mem_rd_data;

  // Arbiter side.
  modport master (
    input  cli_req, cli_we, cli_addr, cli_len, cli_wdata,
    input  mem_wr_ack, mem_rd_ack, mem_rd_data,
    output cli_grant, cli_wr_ack, cli_rd_valid, cli_rd_data, cli_done, cli_err,
    output mem_wr_req, mem_rd_req, mem_addr, mem_len, mem_wr_data
  );

  // Clients plus controller side.
  modport slave (
    output cli_req, cli_we, cli_addr, cli_len, cli_wdata,
    output mem_wr_ack, mem_rd_ack, mem_rd_data,
    input  cli_grant, cli_wr_ack, cli_rd_valid, cli_rd_data, cli_done, cli_err,
    input  mem_wr_req, mem_rd_req, mem_addr, mem_len, mem_wr_data
  );

endinterface

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin selector: lone requester wins, ties go to the rr pointer.
// Latency: combinational.
// Backpressure: none; valid simply reflects any request present.
module sdram_rr_pick (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       sel,
  output logic       valid
);

  // Tie broken by rr; otherwise the single active requester.
  always_comb begin
    valid = |req;
    sel   = (req == 2'b11) ? rr : req[1];
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Grants one of two burst clients to the SDRAM controller, round-robin, with watchdog abort.
// Latency: grant/request 1 cycle after request; done 1 cycle after last ack; beat routing combinational.
// Backpressure: controller acks pace beats; a client waits (request held) until granted.
module sdram_port_arb
  import sdram_pkg::*;
#(
  parameter int TMO_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_end,
  sdram_port_arb_if.master  bus
);

  // Abort fires on the edge where tmo would reach all-ones, i.e. after
  // 2^TMO_W-1 consecutive beatless XFER cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1));

  state_t            state;
  logic              sel;
  logic              we;
  logic              rr;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic [1:0]        err;
  logic              wr_req;
  logic              rd_req;

  logic              pick_sel;
  logic              pick_valid;
  logic              ack;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [LEN_W-1:0]  pick_len;

  sdram_rr_pick u_pick (
    .req   (bus.cli_req),
    .rr    (rr),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  // Candidate transaction fields and the ack that matters for the granted direction.
  always_comb begin
    pick_we   = bus.cli_we[pick_sel];
    pick_addr = pick_sel ? bus.cli_addr[2*ADDR_W-1:ADDR_W] : bus.cli_addr[ADDR_W-1:0];
    pick_len  = pick_sel ? bus.cli_len[2*LEN_W-1:LEN_W]    : bus.cli_len[LEN_W-1:0];
    ack       = we ? bus.mem_wr_ack : bus.mem_rd_ack;
  end

  // Arbitration FSM with registered grant, request and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 1'b0;
      we     <= 1'b0;
      rr     <= 1'b0;
      addr   <= '0;
      len    <= '0;
      cnt    <= '0;
      tmo    <= '0;
      grant  <= '0;
      done   <= '0;
      err    <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (init_end && pick_valid) begin
            sel   <= pick_sel;
            we    <= pick_we;
            addr  <= pick_addr;
            len   <= pick_len;
            cnt   <= '0;
            tmo   <= '0;
            grant <= onehot(pick_sel);
            if (pick_len == '0) begin
              // Empty burst: complete without touching the controller.
              done  <= onehot(pick_sel);
              state <= DONE;
            end else begin
              wr_req <= pick_we;
              rd_req <= !pick_we;
              state  <= XFER;
            end
          end
        end
        XFER: begin
          if (ack) begin
            tmo <= '0;
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == len) begin
              wr_req <= 1'b0;
              rd_req <= 1'b0;
              done   <= onehot(sel);
              state  <= DONE;
            end
          end else if (tmo == TMO_LAST) begin
            tmo    <= tmo + 1'b1;
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            grant  <= '0;
            err    <= onehot(sel);
            rr     <= ~sel;
            state  <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          rr    <= ~sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency beat routing; only the granted client ever sees a strobe.
  always_comb begin
    bus.cli_wr_ack   = '0;
    bus.cli_rd_valid = '0;
    if (state == XFER) begin
      if (we) bus.cli_wr_ack[sel]   = bus.mem_wr_ack;
      else    bus.cli_rd_valid[sel] = bus.mem_rd_ack;
    end
  end

  assign bus.mem_wr_data = sel ? bus.cli_wdata[2*DATA_W-1:DATA_W] : bus.cli_wdata[DATA_W-1:0];
  assign bus.cli_rd_data = bus.mem_rd_data;
  assign bus.cli_grant   = grant;
  assign bus.cli_done    = done;
  assign bus.cli_err     = err;
  assign bus.mem_wr_req  = wr_req;
  assign bus.mem_rd_req  = rd_req;
  assign bus.mem_addr    = addr;
  assign bus.mem_len     = len;

endmodule
